// File: rtl/rtr_credit_pkg.sv
// rtr_credit_pkg: shared constants and helpers for the router credit flag generator.
// Flag field layout: bit FLAG_CREDIT_AVAIL = count != 0, bit FLAG_ALL_FREE = count == buffer_size.
package rtr_credit_pkg;

    localparam int FLAG_CREDIT_AVAIL = 0;
    localparam int FLAG_ALL_FREE     = 1;
    localparam int FLAG_WIDTH        = 2;

    // Ceiling log2: number of bits needed to encode 'value' distinct states (0 for value <= 1).
    function automatic int clogb(input int value);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

    // Flag field index: port-major, then message class, then resource class.
    function automatic int field_index(input int op, input int mc, input int rc,
                                       input int numMc, input int numRc);
        return (op * numMc + mc) * numRc + rc;
    endfunction

endpackage

// File: rtl/rtr_credit_counter.sv
// rtr_credit_counter: one saturating downstream-credit counter with flag decode.
// Optional sticky under/overflow error register when RTR_CREDIT_ERR_CHECK_EN is defined;
// otherwise o_error is tied low and no error state exists.
module rtr_credit_counter
    import rtr_credit_pkg::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int CNT_WIDTH   = clogb(BUFFER_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic                  i_pc_err,
    output logic [FLAG_WIDTH-1:0] o_flags,
    output logic                  o_error
);

    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(BUFFER_SIZE);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_countNext;
    logic                 w_underflow;
    logic                 w_overflow;

    assign w_underflow = i_dec & ~i_inc & (r_count == '0);
    assign w_overflow  = i_inc & ~i_dec & (r_count == FULL);

    // Next count: simultaneous inc and dec cancel; saturate at 0 and at full.
    always_comb begin
        w_countNext = r_count;
        if (i_inc && !i_dec && (r_count != FULL)) begin
            w_countNext = r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            w_countNext = r_count - 1'b1;
        end
    end

    // Counter register; reset restores a full set of credits and overrides any inc/dec.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= FULL;
        end else begin
            r_count <= w_countNext;
        end
    end

    assign o_flags[FLAG_CREDIT_AVAIL] = (r_count != '0);
    assign o_flags[FLAG_ALL_FREE]     = (r_count == FULL);

`ifdef RTR_CREDIT_ERR_CHECK_EN
    logic r_error;

    // Sticky error: set on underflow, overflow or a bad class index on this port; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_underflow || w_overflow || i_pc_err) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    logic w_unusedErrSources;

    assign w_unusedErrSources = w_underflow | w_overflow | i_pc_err;
    assign o_error            = 1'b0;
`endif

endmodule

// File: rtl/rtr_credit_flags_gen.sv
// rtr_credit_flags_gen: per-(port, message class, resource class) credit tracker producing
// the packed two-bit flag vector for the allocator's flag-selection mux.
// Optional sticky error reporting is enabled with the RTR_CREDIT_ERR_CHECK_EN macro.
// An out-of-range returned class index changes no counter; with checking enabled it marks
// every packet class of that port as errored, since no single counter owns the bad index.
module rtr_credit_flags_gen
    import rtr_credit_pkg::*;
#(
    parameter int num_message_classes  = 2,
    parameter int num_resource_classes = 2,
    parameter int num_ports            = 5,
    parameter int buffer_size          = 8,
    parameter int num_packet_classes   = num_message_classes * num_resource_classes,
    parameter int cnt_width            = clogb(buffer_size + 1),
    parameter int pc_idx_width         = (clogb(num_packet_classes) < 1) ? 1 : clogb(num_packet_classes)
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   alloc_valid,
    input  logic [0:num_ports-1]                                   alloc_op,
    input  logic [0:num_message_classes-1]                         alloc_mc,
    input  logic [0:num_resource_classes-1]                        alloc_orc,
    input  logic [0:num_ports-1]                                   cred_valid_op,
    input  logic [0:num_ports*pc_idx_width-1]                      cred_pc_op,
    output logic [0:num_ports*num_packet_classes*FLAG_WIDTH-1]     flags_op_opc,
    output logic [0:num_ports*num_packet_classes-1]                error_op_opc
);

    for (genvar p = 0; p < num_ports; p++) begin : g_port
        logic [pc_idx_width-1:0] w_pcSel;
        logic                    w_pcBad;

        assign w_pcSel = cred_pc_op[p*pc_idx_width +: pc_idx_width];
        assign w_pcBad = cred_valid_op[p] & (int'(w_pcSel) >= num_packet_classes);

        for (genvar m = 0; m < num_message_classes; m++) begin : g_mc
            for (genvar r = 0; r < num_resource_classes; r++) begin : g_rc
                localparam int PC    = m * num_resource_classes + r;
                localparam int FIELD = field_index(p, m, r, num_message_classes, num_resource_classes);

                logic                  w_inc;
                logic                  w_dec;
                logic                  w_err;
                logic [FLAG_WIDTH-1:0] w_flags;

                assign w_inc = cred_valid_op[p] & (w_pcSel == pc_idx_width'(PC));
                assign w_dec = alloc_valid & alloc_op[p] & alloc_mc[m] & alloc_orc[r];

                rtr_credit_counter #(
                    .BUFFER_SIZE (buffer_size),
                    .CNT_WIDTH   (cnt_width)
                ) u_counter (
                    .clk      (clk),
                    .reset    (reset),
                    .i_inc    (w_inc),
                    .i_dec    (w_dec),
                    .i_pc_err (w_pcBad),
                    .o_flags  (w_flags),
                    .o_error  (w_err)
                );

                assign flags_op_opc[FIELD*FLAG_WIDTH + FLAG_CREDIT_AVAIL] = w_flags[FLAG_CREDIT_AVAIL];
                assign flags_op_opc[FIELD*FLAG_WIDTH + FLAG_ALL_FREE]     = w_flags[FLAG_ALL_FREE];
                assign error_op_opc[FIELD]                                = w_err;
            end
        end
    end

endmodule

// File: tb/tb_rtr_credit_flags_gen.sv
// tb_rtr_credit_flags_gen: directed scoreboard bench for rtr_credit_flags_gen.
// Honours RTR_CREDIT_ERR_CHECK_EN when computing expected error bits.
module tb_rtr_credit_flags_gen;

    localparam int NP  = 5;
    localparam int NMC = 2;
    localparam int NRC = 2;
    localparam int NPC = NMC * NRC;
    localparam int BUF = 8;
    localparam int PCW = 2;
    localparam int NF  = NP * NPC;

    typedef struct {
        logic [0:NF*2-1] flags;
        logic [0:NF-1]   err;
        string           tag;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                alloc_valid;
    logic [0:NP-1]       alloc_op;
    logic [0:NMC-1]      alloc_mc;
    logic [0:NRC-1]      alloc_orc;
    logic [0:NP-1]       cred_valid_op;
    logic [0:NP*PCW-1]   cred_pc_op;
    logic [0:NF*2-1]     flags_op_opc;
    logic [0:NF-1]       error_op_opc;

    exp_t          expQ[$];
    int            cnt[NF];
    logic [0:NF-1] errModel;
    int            checks = 0;
    int            errors = 0;

    rtr_credit_flags_gen #(
        .num_message_classes  (NMC),
        .num_resource_classes (NRC),
        .num_ports            (NP),
        .buffer_size          (BUF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_op      (alloc_op),
        .alloc_mc      (alloc_mc),
        .alloc_orc     (alloc_orc),
        .cred_valid_op (cred_valid_op),
        .cred_pc_op    (cred_pc_op),
        .flags_op_opc  (flags_op_opc),
        .error_op_opc  (error_op_opc)
    );

    always #5 clk = ~clk;

    function automatic logic [0:NP*PCW-1] mkPc(input int p0, input int p1, input int p2,
                                               input int p3, input int p4);
        return {2'(p0), 2'(p1), 2'(p2), 2'(p3), 2'(p4)};
    endfunction

    // Drive one cycle of stimulus, advance the model, and queue the expected state after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic av,
                                 input int op, input int mc, input int rc,
                                 input logic [0:NP-1] cv, input logic [0:NP*PCW-1] cpc);
        exp_t e;
        reset         = rst;
        alloc_valid   = av;
        alloc_op      = '0;
        alloc_mc      = '0;
        alloc_orc     = '0;
        if (op >= 0) begin
            alloc_op[op]  = 1'b1;
            alloc_mc[mc]  = 1'b1;
            alloc_orc[rc] = 1'b1;
        end
        cred_valid_op = cv;
        cred_pc_op    = cpc;
        for (int f = 0; f < NF; f++) begin
            int  p;
            int  pc;
            bit  inc;
            bit  dec;
            bit  bad;
            p   = f / NPC;
            pc  = f % NPC;
            dec = av && (p == op) && (pc == mc * NRC + rc);
            inc = cv[p] && (int'(cpc[p*PCW +: PCW]) == pc);
            bad = 1'b0;
            if (rst) begin
                cnt[f]      = BUF;
                errModel[f] = 1'b0;
            end else begin
                if (inc && !dec) begin
                    if (cnt[f] < BUF) cnt[f]++;
                    else bad = 1'b1;
                end else if (dec && !inc) begin
                    if (cnt[f] > 0) cnt[f]--;
                    else bad = 1'b1;
                end
`ifdef RTR_CREDIT_ERR_CHECK_EN
                if (bad) errModel[f] = 1'b1;
`endif
            end
        end
        @(posedge clk);
        #1;
        for (int f = 0; f < NF; f++) begin
            e.flags[f*2]     = (cnt[f] != 0);
            e.flags[f*2 + 1] = (cnt[f] == BUF);
        end
        e.err = errModel;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    // Compare the DUT outputs against one scoreboard entry.
    task automatic checkOutput(input exp_t e);
        checks++;
        if (flags_op_opc !== e.flags) begin
            errors++;
            $display("[TB] FAIL %s flags actual=%h required=%h", e.tag, flags_op_opc, e.flags);
        end
        checks++;
        if (error_op_opc !== e.err) begin
            errors++;
            $display("[TB] FAIL %s errors actual=%h required=%h", e.tag, error_op_opc, e.err);
        end
    endtask

    // Monitor: outputs are registered state, so every negedge with a pending entry is a check point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        errModel = '0;
        for (int f = 0; f < NF; f++) cnt[f] = BUF;

        applyStimulus("reset0", 1'b1, 1'b0, -1, 0, 0, '0, '0);
        applyStimulus("reset1", 1'b1, 1'b0, -1, 0, 0, '0, '0);

        for (int i = 0; i < BUF; i++) begin
            applyStimulus($sformatf("deplete10_%0d", i), 1'b0, 1'b1, 2, 1, 0, '0, '0);
        end
        applyStimulus("underflow10",    1'b0, 1'b1, 2, 1, 0, '0, '0);
        applyStimulus("allocAndCredit", 1'b0, 1'b1, 2, 1, 0, 5'b00100, mkPc(0, 0, 2, 0, 0));
        applyStimulus("creditAlone",    1'b0, 1'b0, -1, 0, 0, 5'b00100, mkPc(0, 0, 2, 0, 0));
        applyStimulus("overflow0",      1'b0, 1'b0, -1, 0, 0, 5'b10000, mkPc(0, 0, 0, 0, 0));
        applyStimulus("idleJunkSel",    1'b0, 1'b0, 3, 0, 1, '0, '0);

        applyStimulus("alloc_f1",  1'b0, 1'b1, 0, 0, 1, '0, '0);
        applyStimulus("alloc_f6",  1'b0, 1'b1, 1, 1, 0, '0, '0);
        applyStimulus("alloc_f10", 1'b0, 1'b1, 2, 1, 0, '0, '0);
        applyStimulus("alloc_f15", 1'b0, 1'b1, 3, 1, 1, '0, '0);
        applyStimulus("alloc_f16", 1'b0, 1'b1, 4, 0, 0, '0, '0);
        applyStimulus("allPortsCredit", 1'b0, 1'b0, -1, 0, 0, 5'b11111, mkPc(1, 2, 2, 3, 0));

        applyStimulus("mixed_f4",  1'b0, 1'b1, 1, 0, 0, '0, '0);
        applyStimulus("resetBusy", 1'b1, 1'b1, 2, 0, 1, 5'b11111, mkPc(0, 1, 2, 3, 0));
        applyStimulus("postReset", 1'b0, 1'b1, 0, 1, 1, '0, '0);
        applyStimulus("quiet",     1'b0, 1'b0, -1, 0, 0, '0, '0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
